rx_deserialiser: RTL and testbench

Converts the bit-by-bit Rx stream from the Miller decoder into the byte-by-byte Rx stream consumed by frame decoding and CRC checking. Collects bits LSB first, emits one full byte per 8 bits and reports a trailing partial byte with its bit count at end of communication. It also forwards start-of-communication (SOC), end-of-communication (EOC) and error events. Every output is registered, and the output obeys all byte-mode Rx stream rules.

---
 rtl/rx_deserialiser.sv | 177 +++++++++++++++++
 tb/tb_rx_deserialiser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_deserialiser.sv
// -----------------------------------------------------------------------------
// rx_deserialiser
//
// Turns the bit-by-bit Rx stream from the Miller decoder into the byte-by-byte
// Rx stream used by frame decoding and CRC checking. Bits are packed into
// bytes (LSB first by default). A full byte is emitted after every 8th bit. A
// trailing partial byte is emitted at end of communication, together with
// its bit count. SOC, EOC and error events are forwarded. Every output is
// registered and responds one cycle after the input event that causes it.
//
// Parameters:
//   LSB_FIRST      1: first received bit lands in out_data[0]; 0: in out_data[7]
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            asynchronous, active-high reset
//   in_soc         bit stream: start of communication (pulse)
//   in_eoc         bit stream: end of communication (pulse)
//   in_data        bit stream: received bit, qualified by in_data_valid
//   in_data_valid  bit stream: in_data valid (pulse)
//   in_error       bit stream: decode error (pulse)
//   out_soc        byte stream: start of communication (pulse)
//   out_eoc        byte stream: end of communication (pulse)
//   out_data       byte stream: assembled byte, held while out_data_valid=0
//   out_data_valid byte stream: out_data valid (pulse)
//   out_data_bits  byte stream: valid bits in out_data, 0 means 8
//   out_error      byte stream: error (pulse)
// -----------------------------------------------------------------------------
module rx_deserialiser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_soc,
    input  logic       in_eoc,
    input  logic       in_data,
    input  logic       in_data_valid,
    input  logic       in_error,
    output logic       out_soc,
    output logic       out_eoc,
    output logic [7:0] out_data,
    output logic       out_data_valid,
    output logic [2:0] out_data_bits,
    output logic       out_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [7:0]  shift_buf, shift_buf_nxt;

    logic        soc_nxt, eoc_nxt, valid_nxt, error_nxt;
    logic [7:0]  data_nxt;
    logic [2:0]  bits_nxt;

    logic [2:0]  bit_pos;
    logic [7:0]  buf_with_bit;

    // The buffer is cleared at every byte boundary, so each position is
    // written exactly once and OR-ing the new bit in is enough. With
    // LSB_FIRST=0 the unused positions of a partial byte are the low bits,
    // which are still zero.
    assign bit_pos      = LSB_FIRST ? cnt : (3'd7 - cnt);
    assign buf_with_bit = shift_buf | (8'(in_data) << bit_pos);

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        shift_buf_nxt = shift_buf;
        soc_nxt       = 1'b0;
        eoc_nxt       = 1'b0;
        valid_nxt     = 1'b0;
        error_nxt     = 1'b0;
        data_nxt      = out_data;
        bits_nxt      = out_data_bits;

        if (in_soc) begin
            // SOC wins over every other flag and silently drops any
            // partial byte of the previous frame.
            state_nxt     = RX;
            cnt_nxt       = 3'd0;
            shift_buf_nxt = 8'h00;
            soc_nxt       = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    error_nxt = in_error;
                end

                RX: begin
                    if (in_error) begin
                        error_nxt     = 1'b1;
                        cnt_nxt       = 3'd0;
                        shift_buf_nxt = 8'h00;
                        if (in_eoc) begin
                            eoc_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = ERR;
                        end
                    end else if (in_eoc) begin
                        state_nxt     = IDLE;
                        eoc_nxt       = 1'b1;
                        cnt_nxt       = 3'd0;
                        shift_buf_nxt = 8'h00;
                        if (cnt != 3'd0) begin
                            valid_nxt = 1'b1;
                            data_nxt  = shift_buf;
                            bits_nxt  = cnt;
                        end
                    end else if (in_data_valid) begin
                        if (cnt == 3'd7) begin
                            // Byte complete: emit it and start the next one
                            // from an empty buffer on the very next bit.
                            valid_nxt     = 1'b1;
                            data_nxt      = buf_with_bit;
                            bits_nxt      = 3'd0;
                            cnt_nxt       = 3'd0;
                            shift_buf_nxt = 8'h00;
                        end else begin
                            shift_buf_nxt = buf_with_bit;
                            cnt_nxt       = cnt + 3'd1;
                        end
                    end
                end

                ERR: begin
                    error_nxt = in_error;
                    if (in_eoc) begin
                        eoc_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            shift_buf      <= 8'h00;
            out_soc        <= 1'b0;
            out_eoc        <= 1'b0;
            out_data       <= 8'h00;
            out_data_valid <= 1'b0;
            out_data_bits  <= 3'd0;
            out_error      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            shift_buf      <= shift_buf_nxt;
            out_soc        <= soc_nxt;
            out_eoc        <= eoc_nxt;
            out_data       <= data_nxt;
            out_data_valid <= valid_nxt;
            out_data_bits  <= bits_nxt;
            out_error      <= error_nxt;
        end
    end

endmodule

// File: tb/tb_rx_deserialiser.sv
// -----------------------------------------------------------------------------
// tb_rx_deserialiser
//
// Directed testbench for rx_deserialiser (LSB_FIRST=1). Inputs are driven 1 ns
// after a rising edge and held for one cycle. The outputs are compared 1 ns
// after the following rising edge, where the response to that input appears.
// Expected values are written out by hand for each step.
// -----------------------------------------------------------------------------
module tb_rx_deserialiser;

    logic       clk;
    logic       rst;
    logic       in_soc;
    logic       in_eoc;
    logic       in_data;
    logic       in_data_valid;
    logic       in_error;
    logic       out_soc;
    logic       out_eoc;
    logic [7:0] out_data;
    logic       out_data_valid;
    logic [2:0] out_data_bits;
    logic       out_error;

    int checks = 0;
    int errors = 0;

    // Flag encoding for {out_soc, out_eoc, out_data_valid, out_error}.
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_SOC  = 4'b1000;
    localparam logic [3:0] F_EOC  = 4'b0100;
    localparam logic [3:0] F_DV   = 4'b0010;
    localparam logic [3:0] F_ERR  = 4'b0001;

    // Last value out_data / out_data_bits are expected to hold.
    logic [7:0] exp_data;
    logic [2:0] exp_bits;

    rx_deserialiser #(.LSB_FIRST(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_soc         (in_soc),
        .in_eoc         (in_eoc),
        .in_data        (in_data),
        .in_data_valid  (in_data_valid),
        .in_error       (in_error),
        .out_soc        (out_soc),
        .out_eoc        (out_eoc),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_data_bits  (out_data_bits),
        .out_error      (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] flags,
                         input logic [7:0] data, input logic [2:0] bits);
        logic [14:0] observed;
        logic [14:0] expected;
        observed = {out_soc, out_eoc, out_data_valid, out_error, out_data, out_data_bits};
        expected = {flags, data, bits};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed soc/eoc/dv/err=%b data=%h bits=%0d, expected soc/eoc/dv/err=%b data=%h bits=%0d",
                   tag, observed[14:11], observed[10:3], observed[2:0],
                   expected[14:11], expected[10:3], expected[2:0]);
        end
    endtask

    // Drive one cycle of inputs; return 1 ns after the edge that samples them.
    task automatic tick(input logic soc, input logic eoc, input logic d,
                        input logic dv, input logic err);
        in_soc        = soc;
        in_eoc        = eoc;
        in_data       = d;
        in_data_valid = dv;
        in_error      = err;
        @(posedge clk);
        #1;
        in_soc        = 1'b0;
        in_eoc        = 1'b0;
        in_data       = 1'b0;
        in_data_valid = 1'b0;
        in_error      = 1'b0;
    endtask

    // Send n bits of value (bit 0 first) back to back. When expect_byte is set
    // the 8th bit must produce the full byte; every other bit must be silent.
    task automatic send_bits(input logic [7:0] value, input int n,
                             input bit expect_byte, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, value[i], 1'b1, 1'b0);
            if (expect_byte && i == 7) begin
                exp_data = value;
                exp_bits = 3'd0;
                check(tag, F_DV, exp_data, exp_bits);
            end else begin
                check(tag, F_NONE, exp_data, exp_bits);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        in_soc        = 1'b0;
        in_eoc        = 1'b0;
        in_data       = 1'b0;
        in_data_valid = 1'b0;
        in_error      = 1'b0;
        exp_data      = 8'h00;
        exp_bits      = 3'd0;

        // Reset values.
        #12;
        check("reset", F_NONE, 8'h00, 3'd0);
        rst = 1'b0;

        // Full byte 0xA5, then EOC with nothing pending.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a5_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'hA5, 8, 1'b1, "a5_bits");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("a5_eoc", F_EOC, 8'hA5, 3'd0);

        // EOC in IDLE is ignored.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_eoc", F_NONE, 8'hA5, 3'd0);

        // 7-bit short frame 1,1,1,0,0,0,0.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("short_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'h07, 7, 1'b0, "short_bits");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_data = 8'h07;
        exp_bits = 3'd7;
        check("short_eoc", F_EOC | F_DV, 8'h07, 3'd7);

        // 0xFF then four zeros: full byte, then partial byte with EOC.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("b12_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'hFF, 8, 1'b1, "b12_ff");
        send_bits(8'h00, 4, 1'b0, "b12_zero");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_data = 8'h00;
        exp_bits = 3'd4;
        check("b12_eoc", F_EOC | F_DV, 8'h00, 3'd4);

        // Error mid-frame: partial byte discarded, later bits ignored.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("err_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'h05, 3, 1'b0, "err_pre");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_pulse", F_ERR, 8'h00, 3'd4);
        send_bits(8'h03, 2, 1'b0, "err_post");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("err_again", F_ERR, 8'h00, 3'd4);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("err_eoc", F_EOC, 8'h00, 3'd4);

        // Error in IDLE is forwarded.
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_err", F_ERR, 8'h00, 3'd4);

        // Error and EOC together in RX: both forwarded, back to IDLE.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ee_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'h02, 2, 1'b0, "ee_bits");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("ee_both", F_EOC | F_ERR, 8'h00, 3'd4);
        send_bits(8'hFF, 8, 1'b0, "ee_idle_bits");

        // SOC restart mid-frame (with a simultaneous EOC that SOC overrides).
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rs_soc1", F_SOC, exp_data, exp_bits);
        send_bits(8'h1F, 5, 1'b0, "rs_part");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rs_soc2", F_SOC, 8'h00, 3'd4);
        send_bits(8'h3C, 8, 1'b1, "rs_3c");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rs_eoc", F_EOC, 8'h3C, 3'd0);

        // Asynchronous reset mid-frame, then bits without SOC.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_soc", F_SOC, exp_data, exp_bits);
        send_bits(8'h0F, 4, 1'b0, "rst_bits");
        rst = 1'b1;
        #1;
        exp_data = 8'h00;
        exp_bits = 3'd0;
        check("rst_async", F_NONE, 8'h00, 3'd0);
        @(posedge clk);
        #1;
        check("rst_hold", F_NONE, 8'h00, 3'd0);
        rst = 1'b0;
        send_bits(8'hFF, 8, 1'b0, "rst_nosoc");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_nosoc_eoc", F_NONE, 8'h00, 3'd0);

        // Fresh frame after reset assembles from an empty buffer.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_soc", F_SOC, 8'h00, 3'd0);
        send_bits(8'h06, 3, 1'b0, "post_bits");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_data = 8'h06;
        exp_bits = 3'd3;
        check("post_eoc", F_EOC | F_DV, 8'h06, 3'd3);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_quiet", F_NONE, 8'h06, 3'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
